dispatch_router: RTL and testbench
==================================

Name: dispatch_router

Overview:
- Sits between Decode and the three reservation stations: ALU RS, LSU RS and branch RS.
- Accepts one decoded micro-op per cycle over a valid/ready handshake and buffers it in a single-entry output slot.
- Assigns each micro-op a ROB tag from a circular allocator and steers it, by ALUOp, to exactly one reservation station.
- Tracks ROB occupancy with a credit counter so it never over-allocates, and supports a full pipeline flush.

Parameters:
- ROB_DEPTH, 16: number of ROB entries; must be a power of two, at least 2.
- TAG_W, $clog2(ROB_DEPTH): width of the ROB tag.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset: reset=0 clears state immediately, and release is synchronous to clk.
- valid_in  in  1  Decode has a micro-op.
- ready_in  out  1  router can accept this cycle.
- PC_in  in  32  PC of the micro-op.
- rs1, rs2, rd  in  5 each  register indices.
- imm  in  32  immediate.
- ALUOp  in  3  op class: 000 I-type, 001 R-type, 101 LUI, 010 load, 011 store, 100 branch, 110 JALR, 111 illegal.
- Opcode  in  7  raw opcode, passed through.
- alu_valid / alu_ready  out / in  1 each  ALU RS handshake.
- lsu_valid / lsu_ready  out / in  1 each  LSU RS handshake.
- br_valid / br_ready  out / in  1 each  branch RS handshake.
- d_PC, d_rs1, d_rs2, d_rd, d_imm, d_ALUOp, d_Opcode  out  32/5/5/5/32/3/7  shared payload bus driven from the slot.
- d_tag  out  TAG_W  ROB tag of the slot micro-op.
- retire_valid  in  1  ROB frees one entry this cycle.
- flush  in  1  synchronous pipeline flush.
- rob_count  out  TAG_W+1  entries currently allocated.
- illegal_op  out  1  one-cycle pulse when an ALUOp=111 micro-op is accepted.

Behaviour:
- Reset (reset=0), asynchronous:
  - Clears slot_valid, alloc_ptr, rob_count and illegal_op.
  - All *_valid outputs read 0 and ready_in reads 0 while reset is asserted.
  - Payload outputs reset to 0.
- Unit steering:
  - ALU for ALUOp 000, 001, 101.
  - LSU for 010, 011.
  - Branch for 100, 110.
  - Exactly one of alu_valid/lsu_valid/br_valid equals slot_valid; the other two are 0.
- fire = slot_valid AND the ready input of the selected unit.
- ready_in = !flush AND (rob_count < ROB_DEPTH) AND (!slot_valid OR fire). This is combinational, so a new micro-op can enter in the same cycle the slot drains.
- Accept = valid_in AND ready_in:
  - Legal op: the slot loads the payload, d_tag <= alloc_ptr, alloc_ptr <= alloc_ptr+1 (wraps ROB_DEPTH-1 -> 0), rob_count increments, slot_valid <= 1.
  - Illegal op (111): consumed with no slot load, no tag and no count change; illegal_op pulses 1 for the next cycle. slot_valid <= 0 if fire, otherwise it holds.
- Latency: exactly 1 cycle from accept to unit *_valid.
- Slot stability: while slot_valid and not fire, all d_* outputs and the unit selection hold stable.
- Fire without accept: slot_valid <= 0.
- rob_count:
  - +1 on a legal accept; -1 on retire_valid; unchanged when both occur in the same cycle.
  - retire_valid with rob_count=0 is ignored; the count saturates at 0.
  - At rob_count=ROB_DEPTH, ready_in=0. A same-cycle retire does not bypass this; acceptance resumes the next cycle.
- flush=1 (priority over everything except reset):
  - Next cycle: slot_valid=0, alloc_ptr=0, rob_count=0, illegal_op=0.
  - ready_in=0 during the flush cycle.
  - retire_valid in the flush cycle is ignored.
  - A slot not fired by the flush cycle is discarded; a slot that fires in the flush cycle counts as delivered.
- Reset mid-operation: any slot contents are discarded, with no partial handshake completion.

Test Plan:
- Reset then three back-to-back legal ops: ALUOp=001, 010, 100, all unit readies=1 → alu_valid, lsu_valid, br_valid each appear one cycle after their accept with d_tag=0,1,2; rob_count=3; ready_in stays 1.
- Backpressure: ALUOp=011 with lsu_ready=0 for 4 cycles → lsu_valid=1 and d_PC/d_imm/d_tag stable for all 4 cycles, ready_in=0; lsu_ready=1 → fire, and a waiting op is accepted in the same cycle.
- Credit exhaustion at ROB_DEPTH=16: 16 legal accepts with no retire → rob_count=16, ready_in=0, 17th valid_in stalls. One retire_valid → ready_in=1 the following cycle, and the new op gets d_tag=0 (wrap).
- Simultaneous accept and retire at rob_count=5 → rob_count stays 5; retire at rob_count=0 → stays 0.
- Illegal op ALUOp=111 accepted → no *_valid, rob_count unchanged, alloc_ptr unchanged, illegal_op=1 for exactly one cycle.
- Flush with slot_valid=1 (br_ready=0) and rob_count=7 → next cycle slot_valid=0, rob_count=0, next accepted op has d_tag=0. Assert reset=0 mid-stall → all *_valid drop immediately.

Source files
------------

// File: rtl/dispatch_router_if.sv
// Decode-to-dispatch bundle: the micro-op in, the RS handshakes and payload out,
// plus the ROB retire and flush controls.
interface dispatch_router_if #(
  parameter int TAG_W = 4
);
  logic              valid_in;
  logic              ready_in;
  logic [31:0]       PC_in;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [4:0]        rd;
  logic [31:0]       imm;
  logic [2:0]        ALUOp;
  logic [6:0]        Opcode;
  logic              alu_valid;
  logic              alu_ready;
  logic              lsu_valid;
  logic              lsu_ready;
  logic              br_valid;
  logic              br_ready;
  logic [31:0]       d_PC;
  logic [4:0]        d_rs1;
  logic [4:0]        d_rs2;
  logic [4:0]        d_rd;
  logic [31:0]       d_imm;
  logic [2:0]        d_ALUOp;
  logic [6:0]        d_Opcode;
  logic [TAG_W-1:0]  d_tag;
  logic              retire_valid;
  logic              flush;
  logic [TAG_W:0]    rob_count;
  logic              illegal_op;

  modport master (
    output valid_in, PC_in, rs1, rs2, rd, imm,
    output ALUOp, Opcode,
    output alu_ready, lsu_ready, br_ready,
    output retire_valid, flush,
    input  ready_in, alu_valid, lsu_valid, br_valid,
    input  d_PC, d_rs1, d_rs2, d_rd, d_imm,
    input  d_ALUOp, d_Opcode, d_tag,
    input  rob_count, illegal_op
  );

  modport slave (
    input  valid_in, PC_in, rs1, rs2, rd, imm,
    input  ALUOp, Opcode,
    input  alu_ready, lsu_ready, br_ready,
    input  retire_valid, flush,
    output ready_in, alu_valid, lsu_valid, br_valid,
    output d_PC, d_rs1, d_rs2, d_rd, d_imm,
    output d_ALUOp, d_Opcode, d_tag,
    output rob_count, illegal_op
  );
endinterface

// File: rtl/dispatch_router.sv
// Dispatch stage: one-entry slot between Decode and the ALU/LSU/branch RSs,
// ROB tag allocation and ROB credit tracking.
module dispatch_router #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  dispatch_router_if.slave  bus
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(ROB_DEPTH);

  logic              slot_valid;
  logic [31:0]       pc_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic [31:0]       imm_q;
  logic [2:0]        op_q;
  logic [6:0]        opc_q;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  alloc_ptr;
  logic [TAG_W:0]    rob_count;
  logic              illegal_q;

  logic sel_alu;
  logic sel_lsu;
  logic sel_br;
  logic fire;
  logic ready;
  logic accept;
  logic legal;
  logic inc;
  logic dec;

  always_comb begin
    sel_alu = 1'b0;
    sel_lsu = 1'b0;
    sel_br  = 1'b0;
    case (op_q)
      3'b000, 3'b001, 3'b101: sel_alu = 1'b1;
      3'b010, 3'b011:         sel_lsu = 1'b1;
      3'b100, 3'b110:         sel_br  = 1'b1;
      default: ;
    endcase
  end

  assign fire = slot_valid &
                ((sel_alu & bus.alu_ready) |
                 (sel_lsu & bus.lsu_ready) |
                 (sel_br  & bus.br_ready));

  // Same-cycle refill: the slot may take a new op while it drains.
  assign ready  = reset & ~bus.flush & (rob_count < FULL) &
                  (~slot_valid | fire);
  assign accept = bus.valid_in & ready;
  assign legal  = (bus.ALUOp != 3'b111);
  assign inc    = accept & legal;
  assign dec    = bus.retire_valid & (rob_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      op_q       <= '0;
      opc_q      <= '0;
      tag_q      <= '0;
      alloc_ptr  <= '0;
      rob_count  <= '0;
      illegal_q  <= 1'b0;
    end else if (bus.flush) begin
      slot_valid <= 1'b0;
      alloc_ptr  <= '0;
      rob_count  <= '0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= accept & ~legal;
      if (inc) begin
        slot_valid <= 1'b1;
        pc_q       <= bus.PC_in;
        rs1_q      <= bus.rs1;
        rs2_q      <= bus.rs2;
        rd_q       <= bus.rd;
        imm_q      <= bus.imm;
        op_q       <= bus.ALUOp;
        opc_q      <= bus.Opcode;
        tag_q      <= alloc_ptr;
        alloc_ptr  <= alloc_ptr + 1'b1;
      end else if (fire) begin
        slot_valid <= 1'b0;
      end
      if (inc && !dec) begin
        rob_count <= rob_count + 1'b1;
      end else if (dec && !inc) begin
        rob_count <= rob_count - 1'b1;
      end
    end
  end

  assign bus.ready_in   = ready;
  assign bus.alu_valid  = slot_valid & sel_alu;
  assign bus.lsu_valid  = slot_valid & sel_lsu;
  assign bus.br_valid   = slot_valid & sel_br;
  assign bus.d_PC       = pc_q;
  assign bus.d_rs1      = rs1_q;
  assign bus.d_rs2      = rs2_q;
  assign bus.d_rd       = rd_q;
  assign bus.d_imm      = imm_q;
  assign bus.d_ALUOp    = op_q;
  assign bus.d_Opcode   = opc_q;
  assign bus.d_tag      = tag_q;
  assign bus.rob_count  = rob_count;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_dispatch_router.sv
// Bench for dispatch_router: reference model plus scoreboard of slot contents,
// and one task per scenario with its own directed checks.
module tb_dispatch_router;

  logic clk;
  logic reset;

  dispatch_router_if #(.TAG_W(4)) bus();

  dispatch_router #(.ROB_DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  tag;
    logic [1:0]  unit;
  } sb_t;

  sb_t        sb[$];
  int         total = 0;
  int         bad = 0;
  int         n_fired = 0;
  int         m_count = 0;
  logic [3:0] m_ptr = '0;
  logic       m_ill = 1'b0;

  function automatic logic [1:0] unit_of(input logic [2:0] op);
    case (op)
      3'b010, 3'b011: return 2'd1;
      3'b100, 3'b110: return 2'd2;
      default:        return 2'd0;
    endcase
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2:0] exp_v;
    logic [2:0] rdy;
    logic       m_fire;
    logic       exp_rdy;
    logic       acc;
    logic       lg;
    logic       dec;
    if (!reset) begin
      total++;
      if ({bus.br_valid, bus.lsu_valid, bus.alu_valid, bus.ready_in}
          !== 4'b0) begin
        bad++;
        $display("FAIL rst_outputs: got v=%b%b%b rdy=%b, want all 0",
                 bus.br_valid, bus.lsu_valid, bus.alu_valid, bus.ready_in);
      end
      sb.delete();
      m_ptr = '0;
      m_count = 0;
      m_ill = 1'b0;
    end else begin
      exp_v = 3'b000;
      if (sb.size() > 0) exp_v[sb[0].unit] = 1'b1;
      total++;
      if ({bus.br_valid, bus.lsu_valid, bus.alu_valid} !== exp_v) begin
        bad++;
        $display("FAIL unit_valid: got %b%b%b, want %b",
                 bus.br_valid, bus.lsu_valid, bus.alu_valid, exp_v);
      end
      if (sb.size() > 0) begin
        total++;
        if (bus.d_tag !== sb[0].tag || bus.d_PC !== sb[0].pc ||
            bus.d_imm !== sb[0].imm) begin
          bad++;
          $display("FAIL payload: got tag=%0d pc=%h imm=%h, want tag=%0d pc=%h imm=%h",
                   bus.d_tag, bus.d_PC, bus.d_imm,
                   sb[0].tag, sb[0].pc, sb[0].imm);
        end
      end
      total++;
      if (bus.rob_count !== 5'(m_count)) begin
        bad++;
        $display("FAIL rob_count: got %0d, want %0d", bus.rob_count, m_count);
      end
      total++;
      if (bus.illegal_op !== m_ill) begin
        bad++;
        $display("FAIL illegal_op: got %b, want %b", bus.illegal_op, m_ill);
      end
      rdy = {bus.br_ready, bus.lsu_ready, bus.alu_ready};
      m_fire = (sb.size() > 0) && rdy[sb[0].unit];
      exp_rdy = !bus.flush && (m_count < 16) && ((sb.size() == 0) || m_fire);
      total++;
      if (bus.ready_in !== exp_rdy) begin
        bad++;
        $display("FAIL ready_in: got %b, want %b", bus.ready_in, exp_rdy);
      end
      acc = bus.valid_in && exp_rdy;
      if (m_fire) begin
        void'(sb.pop_front());
        n_fired++;
      end
      if (bus.flush) begin
        sb.delete();
        m_ptr = '0;
        m_count = 0;
        m_ill = 1'b0;
      end else begin
        lg = (bus.ALUOp != 3'b111);
        m_ill = acc && !lg;
        dec = bus.retire_valid && (m_count != 0);
        if (acc && lg) begin
          sb.push_back('{pc: bus.PC_in, imm: bus.imm, tag: m_ptr,
                         unit: unit_of(bus.ALUOp)});
          m_ptr++;
        end
        m_count = m_count + int'(acc && lg) - int'(dec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic [31:0] pc);
    bus.valid_in = v;
    bus.ALUOp    = op;
    bus.PC_in    = pc;
    bus.imm      = pc ^ 32'h5a5a_0000;
    bus.rs1      = pc[6:2];
    bus.rs2      = pc[7:3];
    bus.rd       = pc[8:4];
    bus.Opcode   = {pc[3:0], op};
  endtask

  task automatic readies(input logic a, input logic l, input logic b);
    bus.alu_ready = a;
    bus.lsu_ready = l;
    bus.br_ready  = b;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 3'b000, 32'h0);
    readies(1'b1, 1'b1, 1'b1);
    bus.retire_valid = 1'b0;
    bus.flush = 1'b0;
    #2;
    total++;
    if (bus.rob_count !== 5'd0 || bus.ready_in !== 1'b0 ||
        bus.d_PC !== 32'h0 || bus.illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: cnt=%0d rdy=%b pc=%h ill=%b, want 0/0/0/0",
               bus.rob_count, bus.ready_in, bus.d_PC, bus.illegal_op);
    end
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = n_fired;
    drive(1'b1, 3'b001, 32'h100);
    step();
    drive(1'b1, 3'b010, 32'h104);
    step();
    drive(1'b1, 3'b100, 32'h108);
    step();
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.rob_count !== 5'd3 || bus.ready_in !== 1'b1 ||
        bus.br_valid !== 1'b1 || bus.d_tag !== 4'd2) begin
      bad++;
      $display("FAIL b2b: cnt=%0d rdy=%b br_v=%b tag=%0d, want 3/1/1/2",
               bus.rob_count, bus.ready_in, bus.br_valid, bus.d_tag);
    end
    step();
    total++;
    if (n_fired - f0 !== 3) begin
      bad++;
      $display("FAIL b2b_delivered: got %0d, want 3", n_fired - f0);
    end
  endtask

  task automatic test_backpressure();
    readies(1'b1, 1'b0, 1'b1);
    drive(1'b1, 3'b011, 32'h200);
    step();
    drive(1'b1, 3'b001, 32'h204);
    repeat (4) begin
      @(negedge clk);
      total++;
      if (bus.lsu_valid !== 1'b1 || bus.d_PC !== 32'h200 ||
          bus.d_imm !== (32'h200 ^ 32'h5a5a_0000) || bus.d_tag !== 4'd3 ||
          bus.ready_in !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold: lsu_v=%b pc=%h tag=%0d rdy=%b, want 1/200/3/0",
                 bus.lsu_valid, bus.d_PC, bus.d_tag, bus.ready_in);
      end
      step();
    end
    bus.lsu_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ready_in !== 1'b1) begin
      bad++;
      $display("FAIL drain_refill: ready_in=%b, want 1", bus.ready_in);
    end
    step();
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.alu_valid !== 1'b1 || bus.d_PC !== 32'h204 || bus.d_tag !== 4'd4) begin
      bad++;
      $display("FAIL refill_op: alu_v=%b pc=%h tag=%0d, want 1/204/4",
               bus.alu_valid, bus.d_PC, bus.d_tag);
    end
    step();
  endtask

  task automatic test_credit();
    readies(1'b1, 1'b1, 1'b1);
    do_flush();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b000, 32'h1000 + 32'(i * 4));
      step();
    end
    drive(1'b1, 3'b001, 32'h2000);
    repeat (2) begin
      @(negedge clk);
      total++;
      if (bus.ready_in !== 1'b0 || bus.rob_count !== 5'd16) begin
        bad++;
        $display("FAIL credit_full: rdy=%b cnt=%0d, want 0/16",
                 bus.ready_in, bus.rob_count);
      end
      step();
    end
    bus.retire_valid = 1'b1;
    @(negedge clk);
    total++;
    if (bus.ready_in !== 1'b0) begin
      bad++;
      $display("FAIL retire_no_bypass: ready_in=%b, want 0", bus.ready_in);
    end
    step();
    bus.retire_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.ready_in !== 1'b1 || bus.rob_count !== 5'd15) begin
      bad++;
      $display("FAIL credit_resume: rdy=%b cnt=%0d, want 1/15",
               bus.ready_in, bus.rob_count);
    end
    step();
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.alu_valid !== 1'b1 || bus.d_tag !== 4'd0 || bus.d_PC !== 32'h2000) begin
      bad++;
      $display("FAIL tag_wrap: alu_v=%b tag=%0d pc=%h, want 1/0/2000",
               bus.alu_valid, bus.d_tag, bus.d_PC);
    end
    step();
  endtask

  task automatic test_simul_retire();
    do_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'b101, 32'h3000 + 32'(i * 4));
      step();
    end
    drive(1'b1, 3'b000, 32'h3100);
    bus.retire_valid = 1'b1;
    step();
    drive(1'b0, 3'b000, 32'h0);
    bus.retire_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rob_count !== 5'd5) begin
      bad++;
      $display("FAIL acc_and_retire: cnt=%0d, want 5", bus.rob_count);
    end
    step();
    bus.retire_valid = 1'b1;
    repeat (6) step();
    bus.retire_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.rob_count !== 5'd0) begin
      bad++;
      $display("FAIL retire_sat: cnt=%0d, want 0", bus.rob_count);
    end
    step();
  endtask

  task automatic test_illegal();
    drive(1'b1, 3'b111, 32'h4000);
    step();
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.illegal_op !== 1'b1 || bus.rob_count !== 5'd0 ||
        {bus.alu_valid, bus.lsu_valid, bus.br_valid} !== 3'b000) begin
      bad++;
      $display("FAIL illegal_pulse: ill=%b cnt=%0d v=%b%b%b, want 1/0/000",
               bus.illegal_op, bus.rob_count,
               bus.alu_valid, bus.lsu_valid, bus.br_valid);
    end
    step();
    drive(1'b1, 3'b010, 32'h4004);
    @(negedge clk);
    total++;
    if (bus.illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL illegal_one_cycle: ill=%b, want 0", bus.illegal_op);
    end
    step();
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.lsu_valid !== 1'b1 || bus.d_tag !== 4'd6) begin
      bad++;
      $display("FAIL illegal_no_tag: lsu_v=%b tag=%0d, want 1/6",
               bus.lsu_valid, bus.d_tag);
    end
    step();
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'b001, 32'h5000 + 32'(i * 4));
      step();
    end
    readies(1'b1, 1'b1, 1'b0);
    drive(1'b1, 3'b100, 32'h5100);
    step();
    drive(1'b0, 3'b000, 32'h0);
    step();
    @(negedge clk);
    total++;
    if (bus.br_valid !== 1'b1 || bus.rob_count !== 5'd7) begin
      bad++;
      $display("FAIL pre_flush: br_v=%b cnt=%0d, want 1/7",
               bus.br_valid, bus.rob_count);
    end
    step();
    bus.flush = 1'b1;
    bus.retire_valid = 1'b1;
    drive(1'b1, 3'b000, 32'h5200);
    @(negedge clk);
    total++;
    if (bus.ready_in !== 1'b0) begin
      bad++;
      $display("FAIL flush_ready: ready_in=%b, want 0", bus.ready_in);
    end
    step();
    bus.flush = 1'b0;
    bus.retire_valid = 1'b0;
    drive(1'b0, 3'b000, 32'h0);
    @(negedge clk);
    total++;
    if (bus.br_valid !== 1'b0 || bus.rob_count !== 5'd0) begin
      bad++;
      $display("FAIL post_flush: br_v=%b cnt=%0d, want 0/0",
               bus.br_valid, bus.rob_count);
    end
    bus.br_ready = 1'b1;
    step();
    drive(1'b1, 3'b110, 32'h5300);
    step();
    drive(1'b0, 3'b000, 32'h0);
    bus.br_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.br_valid !== 1'b1 || bus.d_tag !== 4'd0) begin
      bad++;
      $display("FAIL flush_tag: br_v=%b tag=%0d, want 1/0",
               bus.br_valid, bus.d_tag);
    end
    step();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.alu_valid, bus.lsu_valid, bus.br_valid, bus.ready_in} !== 4'b0 ||
        bus.rob_count !== 5'd0) begin
      bad++;
      $display("FAIL async_reset: v=%b%b%b rdy=%b cnt=%0d, want 000/0/0",
               bus.alu_valid, bus.lsu_valid, bus.br_valid,
               bus.ready_in, bus.rob_count);
    end
    step();
    readies(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (bus.br_valid !== 1'b0 || bus.ready_in !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: br_v=%b rdy=%b, want 0/1",
               bus.br_valid, bus.ready_in);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_credit();
    test_simul_retire();
    test_illegal();
    test_flush();
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
